memory_controller_burst: RTL

- Parametrised successor to the single-word PSRAM memory controller.
- Moves a whole line of WORDS 32-bit words per request over the byte-stream PSRAM controller interface (rd/rend/we/wend strobes, byte_available and ready_for_next_byte edges).
- Sits between the cache refill/writeback port and the fast PSRAM controller; the controller instance is external, so its handshake is visible at this block's ports.

---
 rtl/memory_controller_burst.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_controller_burst.sv
// memory_controller_burst
//
// Moves one cache line of WORDS 32-bit words per request over the byte-stream
// PSRAM controller interface. The PSRAM controller is external; its handshake
// appears on the m_* ports.
//
// Ports:
//   clk_mem, rst            memory clock; synchronous active-high reset
//   a, d, we, rd            line address, write line, write/read request (we wins)
//   spo, ready, err         read line, idle-and-ready, sticky timeout flag
//   m_rd, m_we              one-cycle burst start strobes
//   m_rend, m_wend          end-of-burst indications
//   m_a, m_din, m_dout      line-aligned burst address, write byte, read byte
//   m_byte_available        rising edge: m_dout valid
//   m_ready_for_next_byte   rising edge: m_din consumed
//   m_ready                 PSRAM controller idle
//
// Build option: define MEMCTL_BURST_TIMEOUT_EN to add a watchdog that aborts a
// stalled burst after TIMEOUT_CYC cycles and sets err. Without it err is 0.

module memory_controller_burst #(
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned WORDS       = 4,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic                clk_mem,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   a,
    input  logic [32*WORDS-1:0] d,
    input  logic                we,
    input  logic                rd,
    output logic [32*WORDS-1:0] spo,
    output logic                ready,
    output logic                err,
    output logic                m_rd,
    output logic                m_we,
    output logic                m_rend,
    output logic                m_wend,
    output logic [ADDR_W-1:0]   m_a,
    output logic [7:0]          m_din,
    input  logic [7:0]          m_dout,
    input  logic                m_byte_available,
    input  logic                m_ready_for_next_byte,
    input  logic                m_ready
);

    localparam int unsigned NB = 4 * WORDS;
    localparam int unsigned OW = $clog2(NB);
    // One extra bit so the NB terminal count is representable.
    localparam int unsigned IW = OW + 1;

    typedef enum logic [2:0] {StIdle, StWrWait, StWr, StRdWait, StRd} state_e;

    state_e                state_q;
    logic [NB-1:0][7:0]    buf_q;
    logic [IW-1:0]         idx_q;
    logic [32*WORDS-1:0]   spo_q;
    logic [ADDR_W-1:0]     m_a_q;
    logic                  m_rd_q, m_we_q, m_rend_q, m_wend_q;
    logic                  ready_r_q;
    logic                  ba_old_q, rfnb_old_q;
    logic                  ba_rise, rfnb_rise;

    logic [OW-1:0] unused_a;
    assign unused_a = a[OW-1:0];

    assign ba_rise   = m_byte_available & ~ba_old_q;
    assign rfnb_rise = m_ready_for_next_byte & ~rfnb_old_q;

    assign spo    = spo_q;
    assign ready  = ready_r_q & ~(rd | we);
    assign m_rd   = m_rd_q;
    assign m_we   = m_we_q;
    assign m_rend = m_rend_q;
    assign m_wend = m_wend_q;
    assign m_a    = m_a_q;
    // At the terminal count the low bits wrap to byte 0; m_din is not consumed then.
    assign m_din  = buf_q[idx_q[IW-2:0]];

`ifdef MEMCTL_BURST_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] tmo_q;
    logic          tmo_clr, tmo_hit;
    logic          err_q;

    assign err = err_q;

    // Restart on every state entry and on every accepted byte edge.
    always_comb begin
        tmo_clr = 1'b1;
        unique case (state_q)
            StWrWait, StRdWait: tmo_clr = m_ready;
            StWr:               tmo_clr = rfnb_rise;
            StRd:               tmo_clr = ba_rise;
            default:            tmo_clr = 1'b1;
        endcase
    end

    // tmo_q counts elapsed cycles; the hit fires on the TIMEOUT_CYC-th one.
    assign tmo_hit = (state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_mem) begin
        if (rst || tmo_clr) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC == 0);
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk_mem) begin
        if (rst) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            idx_q      <= '0;
            spo_q      <= '0;
            m_a_q      <= '0;
            m_rd_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_rend_q   <= 1'b0;
            m_wend_q   <= 1'b0;
            ready_r_q  <= m_ready;
            ba_old_q   <= 1'b0;
            rfnb_old_q <= 1'b0;
`ifdef MEMCTL_BURST_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            ba_old_q   <= m_byte_available;
            rfnb_old_q <= m_ready_for_next_byte;
`ifdef MEMCTL_BURST_TIMEOUT_EN
            if (tmo_hit) begin
                // Abort: flag it, signal end of burst, keep the old read line.
                err_q   <= 1'b1;
                m_rd_q  <= 1'b0;
                m_we_q  <= 1'b0;
                if (state_q inside {StWrWait, StWr}) begin
                    m_wend_q <= 1'b1;
                end else begin
                    m_rend_q <= 1'b1;
                end
                state_q <= StIdle;
            end else
`endif
            begin
                unique case (state_q)
                    StIdle: begin
                        m_a_q    <= {a[ADDR_W-1:OW], {OW{1'b0}}};
                        buf_q    <= d;
                        m_rend_q <= 1'b0;
                        m_wend_q <= 1'b0;
                        if (we) begin
                            ready_r_q <= 1'b0;
                            idx_q     <= '0;
                            state_q   <= StWrWait;
                        end else if (rd) begin
                            ready_r_q <= 1'b0;
                            idx_q     <= '0;
                            state_q   <= StRdWait;
                        end else begin
                            ready_r_q <= m_ready;
                        end
                    end
                    StWrWait: begin
                        if (m_ready) begin
                            m_we_q  <= 1'b1;
                            state_q <= StWr;
                        end
                    end
                    StWr: begin
                        m_we_q <= 1'b0;
                        if (idx_q == IW'(NB)) begin
                            m_wend_q <= 1'b1;
                            state_q  <= StIdle;
                        end else if (rfnb_rise) begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                    StRdWait: begin
                        if (m_ready) begin
                            m_rd_q  <= 1'b1;
                            state_q <= StRd;
                        end
                    end
                    StRd: begin
                        m_rd_q <= 1'b0;
                        // Early end-of-read: raised while the last byte is still pending.
                        if (idx_q == IW'(NB - 1)) begin
                            m_rend_q <= 1'b1;
                        end
                        if (idx_q == IW'(NB)) begin
                            spo_q   <= buf_q;
                            state_q <= StIdle;
                        end else if (ba_rise) begin
                            buf_q[idx_q[IW-2:0]] <= m_dout;
                            idx_q                <= idx_q + IW'(1);
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
